// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan of an 8-digit common-anode
// seven-segment display. Frame-synchronous word commit, anode dead time,
// leading-zero blanking and invalid-BCD flagging.

// Per-digit lane: classifies one nibble of the committed word (for blanking)
// and one nibble of the pending word (for the error flag taken at commit).
module seven_seg_scan_lane (
  input  logic [3:0] i_act_nib,
  input  logic [3:0] i_pend_nib,
  output logic       o_zero,
  output logic       o_bad
);

  assign o_zero = (i_act_nib == 4'd0);
  assign o_bad  = (i_pend_nib > 4'd9);

endmodule

module seven_seg_scan_ctrl #(
  parameter int CLK_DIV     = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        load,
  input  logic        lzb,
  output logic [7:0]  AN,
  output logic [3:0]  digit,
  output logic        bcd_err,
  output logic        frame
);

  localparam int NUM_DIGITS = 8;
  localparam int MAX_CNT    = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DRV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Phase control
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_idx;
  // First cycle after reset is treated as a DEAD entry with commit.
  logic                   r_first;

  // Datapath
  logic [31:0]            r_pending;
  logic [31:0]            r_active;
  logic                   r_lzb_act;
  logic [7:0]             r_an;
  logic [3:0]             r_digit;
  logic                   r_bcd_err;
  logic                   r_frame;

  // Next-state / next-output
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [2:0]             w_idx_nxt;
  logic                   w_commit;
  logic [7:0]             w_an_nxt;
  logic [3:0]             w_digit_nxt;

  // Lane results
  logic [NUM_DIGITS-1:0]  w_zero;
  logic [NUM_DIGITS-1:0]  w_bad;
  logic [NUM_DIGITS-1:0]  w_blank;
  logic                   w_bcd_err_nxt;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    seven_seg_scan_lane u_lane (
      .i_act_nib  (r_active[4*k +: 4]),
      .i_pend_nib (r_pending[4*k +: 4]),
      .o_zero     (w_zero[k]),
      .o_bad      (w_bad[k])
    );
  end

  // Any invalid nibble in the word about to be committed.
  assign w_bcd_err_nxt = |w_bad;

  // Blank digit k (k>=1) when it and every digit above it is zero; digit 0
  // always shows so an all-zero word still reads "0".
  always_comb begin
    logic hi_zero;
    w_blank = '0;
    hi_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      hi_zero    = hi_zero & w_zero[k];
      w_blank[k] = r_lzb_act & hi_zero;
    end
  end

  // Phase FSM next state and the registered-output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_commit    = 1'b0;
    w_an_nxt    = r_an;
    w_digit_nxt = r_digit;
    if (r_first) begin
      // DEAD entry right after reset: commit and present digit 0.
      w_commit    = 1'b1;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_DEAD;
      w_an_nxt    = 8'hFF;
      w_digit_nxt = r_pending[3:0];
    end else begin
      unique case (r_state)
        ST_DEAD: begin
          if (r_cnt == DEAD_LAST) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = '0;
            w_an_nxt    = w_blank[r_idx] ? 8'hFF : ~(8'd1 << r_idx);
          end
        end
        ST_DRIVE: begin
          if (r_cnt == DRV_LAST) begin
            w_state_nxt = ST_DEAD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 3'd1;
            w_an_nxt    = 8'hFF;
            if (r_idx == 3'd7) begin
              // Wrap: the new frame shows the freshly committed word.
              w_commit    = 1'b1;
              w_digit_nxt = r_pending[3:0];
            end else begin
              w_digit_nxt = r_active[{w_idx_nxt, 2'b00} +: 4];
            end
          end
        end
        default: begin
          w_state_nxt = ST_DEAD;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Phase FSM state, counter and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_DEAD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_first <= 1'b0;
    end
  end

  // Word capture, frame commit and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_active  <= '0;
      r_lzb_act <= 1'b0;
      r_an      <= 8'hFF;
      r_digit   <= 4'd0;
      r_bcd_err <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      // A load on the commit edge lands here and waits for the next frame,
      // since the commit below reads the pre-edge pending value.
      if (load) r_pending <= data;
      if (w_commit) begin
        r_active  <= r_pending;
        r_lzb_act <= lzb;
        r_bcd_err <= w_bcd_err_nxt;
      end
      r_frame <= w_commit;
      r_an    <= w_an_nxt;
      r_digit <= w_digit_nxt;
    end
  end

  assign AN      = r_an;
  assign digit   = r_digit;
  assign bcd_err = r_bcd_err;
  assign frame   = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (CLK_DIV=4, DEAD_CYCLES=1).
// Each frame's expected word/lzb is queued when its loads are driven and
// popped when the DUT's frame pulse starts that frame.
module tb_seven_seg_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEAD    = 1;
  localparam int SLOT    = CLK_DIV + DEAD;
  localparam int FRAME   = 8 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic        load;
  logic        lzb;
  logic [7:0]  AN;
  logic [3:0]  digit;
  logic        bcd_err;
  logic        frame;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .load    (load),
    .lzb     (lzb),
    .AN      (AN),
    .digit   (digit),
    .bcd_err (bcd_err),
    .frame   (frame)
  );

  typedef struct packed {
    logic [31:0] word;
    logic        lzb;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_an(input logic [31:0] w, input logic z, input int s);
    if (s != 0 && z && ((w >> (4 * s)) == 32'd0)) return 8'hFF;
    return ~(8'd1 << s);
  endfunction

  function automatic logic bcd_bad(input logic [31:0] w);
    for (int k = 0; k < 8; k++)
      if (w[4*k +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Called just after a commit edge; checks the whole frame, applies up to two
  // loads at frame offsets e1/e2, sets lzb for the next commit, and ends just
  // after the next commit edge.
  task automatic run_frame(input logic nxt_lzb, input int e1, input logic [31:0] w1,
                           input int e2, input logic [31:0] w2);
    exp_t        cur;
    logic        late;
    logic [31:0] late_w;
    late   = 1'b0;
    late_w = '0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      cur = sb.pop_front();
      for (int e = 0; e < FRAME; e++) begin
        int s;
        int ph;
        s  = e / SLOT;
        ph = e % SLOT;
        chk("frame", {31'b0, frame}, {31'b0, (e == 0)});
        chk("bcd_err", {31'b0, bcd_err}, {31'b0, bcd_bad(cur.word)});
        chk("an", {24'b0, AN}, {24'b0, (ph == 0) ? 8'hFF : exp_an(cur.word, cur.lzb, s)});
        chk("digit", {28'b0, digit}, {28'b0, cur.word[4*s +: 4]});
        load = 1'b0;
        if (e == 0) lzb = nxt_lzb;
        if (e == e1 || e == e2) begin
          load = 1'b1;
          data = (e == e1) ? w1 : w2;
          // Loaded on the commit edge itself: belongs to the frame after next.
          if (e == FRAME - 1) begin
            late   = 1'b1;
            late_w = data;
          end else begin
            m_pending = data;
          end
        end
        if (e == FRAME - 1) sb.push_back('{word: m_pending, lzb: lzb});
        step();
      end
      load = 1'b0;
      if (late) m_pending = late_w;
    end
  endtask

  initial begin
    exp_t cur;
    reset     = 1'b1;
    load      = 1'b0;
    lzb       = 1'b0;
    data      = '0;
    m_pending = '0;
    step();
    step();
    chk("rst_an", {24'b0, AN}, 32'hFF);
    chk("rst_digit", {28'b0, digit}, 32'h0);
    chk("rst_frame", {31'b0, frame}, 32'h0);
    chk("rst_err", {31'b0, bcd_err}, 32'h0);

    // Reset dominates load.
    load = 1'b1;
    data = 32'hDEADBEEF;
    step();
    load = 1'b0;

    reset = 1'b0;
    sb.push_back('{word: 32'h0, lzb: 1'b0});
    step();

    run_frame(1'b0, 10, 32'h87654321, -1, 32'h0);               // zeros
    run_frame(1'b1,  5, 32'h00000120, -1, 32'h0);               // 87654321
    run_frame(1'b1,  5, 32'h00000000, -1, 32'h0);               // 120, blanked
    run_frame(1'b0,  3, 32'h11111111, 30, 32'h22222222);        // all zero, lzb
    run_frame(1'b0, 20, 32'h33333333, FRAME-1, 32'h99999999);   // 2s
    run_frame(1'b0, -1, 32'h0, -1, 32'h0);                      // 3s
    run_frame(1'b1,  2, 32'h0000A005, -1, 32'h0);               // 9s
    run_frame(1'b0,  2, 32'h00000005, -1, 32'h0);               // A005, lzb
    run_frame(1'b0, -1, 32'h0, -1, 32'h0);                      // 5

    // Next frame shows 5 without blanking; reset it during digit 5's drive.
    cur = sb.pop_front();
    chk("f9_frame", {31'b0, frame}, 32'h1);
    for (int e = 0; e < 3 * SLOT + 12; e++) step();
    chk("f9_an_d5", {24'b0, AN}, {24'b0, exp_an(cur.word, cur.lzb, 5)});
    reset = 1'b1;
    step();
    chk("mid_rst_an", {24'b0, AN}, 32'hFF);
    chk("mid_rst_digit", {28'b0, digit}, 32'h0);
    chk("mid_rst_frame", {31'b0, frame}, 32'h0);
    reset     = 1'b0;
    m_pending = '0;
    sb.delete();
    sb.push_back('{word: 32'h0, lzb: 1'b0});
    step();
    run_frame(1'b0, -1, 32'h0, -1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
